// File: rtl/lcd_frame_streamer_if.sv
// Pixel-in / byte-out bundle between the frame streamer and its neighbours.
// master = the streamer (consumes pixels, drives PHY bytes); slave = the far side.
interface lcd_frame_streamer_if;
  logic [15:0] px_data;
  logic        px_valid;
  logic        px_ready;
  logic [7:0]  phy_data;
  logic        phy_rs;
  logic        phy_valid;
  logic        phy_ready;
  logic        phy_fmark_stb;

  modport master (
    input  px_data, px_valid, phy_ready, phy_fmark_stb,
    output px_ready, phy_data, phy_rs, phy_valid
  );

  modport slave (
    output px_data, px_valid, phy_ready, phy_fmark_stb,
    input  px_ready, phy_data, phy_rs, phy_valid
  );
endinterface

// File: rtl/lcd_frame_streamer.sv
// Window-setup header plus RGB565 high/low byte stream into the LCD parallel PHY.
// Registered byte output at 1 byte/clk; a stalled phy_ready holds the byte and drops px_ready.
module lcd_frame_streamer #(
  parameter int         COORD_W   = 9,
  parameter logic [7:0] CMD_CASET = 8'h2A,
  parameter logic [7:0] CMD_PASET = 8'h2B,
  parameter logic [7:0] CMD_RAMWR = 8'h2C
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sync_fmark,
  input  logic [COORD_W-1:0] win_x0,
  input  logic [COORD_W-1:0] win_x1,
  input  logic [COORD_W-1:0] win_y0,
  input  logic [COORD_W-1:0] win_y1,
  output logic               busy,
  output logic               done_stb,
  lcd_frame_streamer_if.master bus
);
  localparam int CNT_W = 2*COORD_W + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_WAIT_FM, S_HDR, S_PIX_HI, S_PIX_LO, S_DRAIN, S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [COORD_W-1:0] x0_q, x1_q, y0_q, y1_q;
  logic               sync_q;
  logic [CNT_W-1:0]   pix_cnt;
  logic [3:0]         hdr_idx;
  logic [7:0]         lo_byte;

  logic               slot_free, bad_win, px_acc, hdr_load;
  logic               load_en, load_rs, hdr_rs;
  logic [7:0]         load_dat, hdr_dat;
  logic [15:0]        x0_w, x1_w, y0_w, y1_w;
  logic [COORD_W:0]   w_span, h_span;

  assign slot_free = !bus.phy_valid || bus.phy_ready;
  assign bad_win   = (x1_q < x0_q) || (y1_q < y0_q);
  assign w_span    = {1'b0, x1_q} - {1'b0, x0_q} + (COORD_W+1)'(1);
  assign h_span    = {1'b0, y1_q} - {1'b0, y0_q} + (COORD_W+1)'(1);
  assign x0_w      = 16'(x0_q);
  assign x1_w      = 16'(x1_q);
  assign y0_w      = 16'(y0_q);
  assign y1_w      = 16'(y1_q);

  always_comb begin
    hdr_dat = 8'h00;
    hdr_rs  = 1'b1;
    case (hdr_idx)
      4'd0:  begin hdr_dat = CMD_CASET; hdr_rs = 1'b0; end
      4'd1:  hdr_dat = x0_w[15:8];
      4'd2:  hdr_dat = x0_w[7:0];
      4'd3:  hdr_dat = x1_w[15:8];
      4'd4:  hdr_dat = x1_w[7:0];
      4'd5:  begin hdr_dat = CMD_PASET; hdr_rs = 1'b0; end
      4'd6:  hdr_dat = y0_w[15:8];
      4'd7:  hdr_dat = y0_w[7:0];
      4'd8:  hdr_dat = y1_w[15:8];
      4'd9:  hdr_dat = y1_w[7:0];
      4'd10: begin hdr_dat = CMD_RAMWR; hdr_rs = 1'b0; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_SETUP;
      S_SETUP:   state_nxt = bad_win ? S_DONE : (sync_q ? S_WAIT_FM : S_HDR);
      // the strobe cycle already loads CASET so it appears the very next cycle
      S_WAIT_FM: if (bus.phy_fmark_stb) state_nxt = S_HDR;
      S_HDR:     if (slot_free && hdr_idx == 4'd10) state_nxt = S_PIX_HI;
      S_PIX_HI:  if (px_acc) state_nxt = S_PIX_LO;
      S_PIX_LO:  if (slot_free) state_nxt = (pix_cnt == '0) ? S_DRAIN : S_PIX_HI;
      S_DRAIN:   if (slot_free) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != S_IDLE);
    done_stb     = (state == S_DONE);
    bus.px_ready = (state == S_PIX_HI) && slot_free;
    px_acc       = bus.px_ready && bus.px_valid;
    hdr_load     = slot_free && ((state == S_HDR) ||
                                 (state == S_WAIT_FM && bus.phy_fmark_stb));
    load_en  = 1'b0;
    load_dat = 8'h00;
    load_rs  = 1'b1;
    if (hdr_load) begin
      load_en  = 1'b1;
      load_dat = hdr_dat;
      load_rs  = hdr_rs;
    end else if (px_acc) begin
      load_en  = 1'b1;
      load_dat = bus.px_data[15:8];
    end else if (state == S_PIX_LO && slot_free) begin
      load_en  = 1'b1;
      load_dat = lo_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x0_q          <= '0;
      x1_q          <= '0;
      y0_q          <= '0;
      y1_q          <= '0;
      sync_q        <= 1'b0;
      pix_cnt       <= '0;
      hdr_idx       <= 4'd0;
      lo_byte       <= 8'h00;
      bus.phy_data  <= 8'h00;
      bus.phy_rs    <= 1'b0;
      bus.phy_valid <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        x0_q   <= win_x0;
        x1_q   <= win_x1;
        y0_q   <= win_y0;
        y1_q   <= win_y1;
        sync_q <= sync_fmark;
      end
      if (state == S_SETUP) begin
        pix_cnt <= CNT_W'(w_span) * CNT_W'(h_span);
        hdr_idx <= 4'd0;
      end
      if (hdr_load) hdr_idx <= hdr_idx + 4'd1;
      if (px_acc) begin
        lo_byte <= bus.px_data[7:0];
        pix_cnt <= pix_cnt - CNT_W'(1);
      end
      if (load_en) begin
        bus.phy_data  <= load_dat;
        bus.phy_rs    <= load_rs;
        bus.phy_valid <= 1'b1;
      end else if (bus.phy_ready) begin
        bus.phy_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_lcd_frame_streamer.sv
// Table of windows run with random pixels / random PHY stalls against a byte-list model,
// plus hand sequences for power-on reset and reset in the middle of a frame.
module tb_lcd_frame_streamer;
  localparam int FM_K   = 20;
  localparam int BUDGET = 20000;

  logic       clk, rst, start, sync_fmark, busy, done_stb;
  logic [8:0] win_x0, win_x1, win_y0, win_y1;

  lcd_frame_streamer_if bus();

  lcd_frame_streamer dut (
    .clk(clk), .rst(rst), .start(start), .sync_fmark(sync_fmark),
    .win_x0(win_x0), .win_x1(win_x1), .win_y0(win_y0), .win_y1(win_y1),
    .busy(busy), .done_stb(done_stb), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int x0, x1, y0, y1;
    bit sync, rnd_rdy, rnd_pv, restart;
    int exp_pix, exp_bytes;
  } vec_t;

  vec_t vecs[9];

  int checks = 0, errors = 0;
  logic [15:0] pix_q[$];
  logic [8:0]  exp_q[$], got_q[$];

  bit   mon_en = 0, stall_q = 0;
  int   cyc = 0, st_cyc, first_vld, first_hs, last_hs, done_cyc, px_acc, done_cnt;
  bit   pxr_seen;
  logic [7:0] prev_dat;
  logic       prev_rs;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, $signed(act), $signed(exp));
    end
  endtask

  // Observe at negedge what the next posedge will transfer.
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (start && st_cyc < 0) st_cyc = cyc;
      if (bus.phy_valid && first_vld < 0) first_vld = cyc;
      if (bus.px_ready) pxr_seen = 1;
      if (bus.phy_valid && bus.phy_ready) begin
        got_q.push_back({bus.phy_rs, bus.phy_data});
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
      if (bus.px_valid && bus.px_ready) px_acc++;
      if (done_stb) begin done_cnt++; done_cyc = cyc; end
    end
    if (stall_q && bus.phy_valid)
      chk("hold_stable", {23'd0, bus.phy_rs, bus.phy_data}, {23'd0, prev_rs, prev_dat});
    stall_q  = bus.phy_valid && !bus.phy_ready;
    prev_dat = bus.phy_data;
    prev_rs  = bus.phy_rs;
  end

  task automatic mon_clear();
    got_q.delete();
    px_acc = 0; done_cnt = 0; pxr_seen = 0;
    st_cyc = -1; first_vld = -1; first_hs = -1; last_hs = -1; done_cyc = -1;
  endtask

  task automatic push_coord(input int v);
    logic [15:0] c;
    c = 16'(v);
    exp_q.push_back({1'b1, c[15:8]});
    exp_q.push_back({1'b1, c[7:0]});
  endtask

  task automatic build_model(input vec_t v, output int n);
    logic [15:0] p;
    pix_q.delete();
    exp_q.delete();
    n = (v.x1 >= v.x0 && v.y1 >= v.y0) ? (v.x1 - v.x0 + 1) * (v.y1 - v.y0 + 1) : 0;
    for (int i = 0; i < n + 8; i++) pix_q.push_back(16'($urandom));
    if (n > 0) begin
      exp_q.push_back({1'b0, 8'h2A}); push_coord(v.x0); push_coord(v.x1);
      exp_q.push_back({1'b0, 8'h2B}); push_coord(v.y0); push_coord(v.y1);
      exp_q.push_back({1'b0, 8'h2C});
      for (int i = 0; i < n; i++) begin
        p = pix_q[i];
        exp_q.push_back({1'b1, p[15:8]});
        exp_q.push_back({1'b1, p[7:0]});
      end
    end
  endtask

  function automatic logic [15:0] cur_pix();
    return (px_acc < pix_q.size()) ? pix_q[px_acc] : 16'hDEAD;
  endfunction

  task automatic run_frame(input vec_t v, input string nm);
    int  n, k, bad;
    bit  fin;
    logic [8:0] g, e;
    build_model(v, n);
    mon_clear();
    mon_en = 1;
    k = 0; fin = 0;
    while (!fin && k < BUDGET) begin
      @(posedge clk); #1;
      if (done_cnt > 0) fin = 1;
      else begin
        start = (k == 0) || (v.restart && k == 40);
        if (k == 0) begin
          win_x0 = 9'(v.x0); win_x1 = 9'(v.x1);
          win_y0 = 9'(v.y0); win_y1 = 9'(v.y1);
          sync_fmark = v.sync;
        end else if (k == 40) begin
          win_x0 = 9'd0; win_x1 = 9'd0; win_y0 = 9'd0; win_y1 = 9'd0;
          sync_fmark = 1'b1;
        end
        bus.phy_fmark_stb = v.sync && (k == 0 || k == 1 || k == FM_K);
        bus.phy_ready     = v.rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.px_valid      = v.rnd_pv ? ($urandom_range(0, 3) != 0) : 1'b1;
        bus.px_data       = cur_pix();
        k++;
      end
    end
    chk({nm, "_done_seen"}, fin, 1);
    if (fin) begin
      chk({nm, "_busy_after_done"}, busy, 0);
      chk({nm, "_done_one_cycle"}, done_stb, 0);
    end
    start = 0; bus.px_valid = 0; bus.phy_fmark_stb = 0; bus.phy_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_done_count"}, done_cnt, 1);
    chk({nm, "_pixels"}, px_acc, v.exp_pix);
    chk({nm, "_nbytes"}, got_q.size(), v.exp_bytes);
    if (n == 0) begin
      chk({nm, "_rej_latency"}, done_cyc - st_cyc, 2);
      chk({nm, "_rej_px_ready"}, pxr_seen, 0);
      chk({nm, "_rej_no_valid"}, first_vld, -1);
    end else begin
      chk({nm, "_first_valid"}, first_vld - st_cyc, v.sync ? FM_K + 1 : 3);
      if (!v.rnd_rdy && !v.rnd_pv)
        chk({nm, "_back_to_back"}, last_hs - first_hs, v.exp_bytes - 1);
    end
    bad = -1;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      g = got_q[bad]; e = exp_q[bad];
      $display("FAIL %s_stream byte %0d got rs=%b %h expected rs=%b %h",
               nm, bad, g[8], g[7:0], e[8], e[7:0]);
    end else if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_stream length got %0d expected %0d", nm, got_q.size(), exp_q.size());
    end
    mon_en = 0;
  endtask

  initial begin
    vecs[0] = '{0, 1, 0, 0,           0, 0, 0, 0, 2, 15};
    vecs[1] = '{0, 1, 0, 0,           0, 1, 0, 0, 2, 15};
    vecs[2] = '{5, 4, 0, 0,           0, 0, 0, 0, 0, 0};
    vecs[3] = '{0, 0, 3, 2,           0, 1, 0, 0, 0, 0};
    vecs[4] = '{10, 13, 100, 102,     0, 1, 1, 0, 12, 35};
    vecs[5] = '{300, 319, 230, 239,   0, 0, 0, 0, 200, 411};
    vecs[6] = '{0, 31, 0, 15,         0, 1, 1, 1, 512, 1035};
    vecs[7] = '{511, 511, 511, 511,   0, 0, 0, 0, 1, 13};
    vecs[8] = '{2, 3, 4, 4,           1, 0, 0, 0, 2, 15};

    rst = 1; start = 0; sync_fmark = 0;
    win_x0 = 0; win_x1 = 0; win_y0 = 0; win_y1 = 0;
    bus.px_data = 16'h0; bus.px_valid = 0; bus.phy_ready = 1; bus.phy_fmark_stb = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done_stb, 0);
    chk("rst_px_ready", bus.px_ready, 0);
    chk("rst_phy_valid", bus.phy_valid, 0);
    chk("rst_phy_data", bus.phy_data, 0);
    chk("rst_phy_rs", bus.phy_rs, 0);
    rst = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // Reset while the 11th pixel is in flight, then a fresh frame must start cleanly.
    begin
      vec_t r;
      int   n, k;
      r = '{0, 7, 0, 3, 0, 0, 0, 0, 32, 75};
      build_model(r, n);
      mon_clear();
      mon_en = 1;
      @(posedge clk); #1;
      win_x0 = 9'd0; win_x1 = 9'd7; win_y0 = 9'd0; win_y1 = 9'd3; sync_fmark = 0;
      start = 1; bus.px_valid = 1; bus.phy_ready = 1; bus.px_data = cur_pix();
      k = 0;
      while (px_acc < 10 && k < 500) begin
        @(posedge clk); #1;
        start = 0;
        bus.px_data = cur_pix();
        k++;
      end
      chk("midrst_reached_px10", px_acc, 10);
      rst = 1;
      @(posedge clk); #1;
      chk("midrst_phy_valid", bus.phy_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_px_ready", bus.px_ready, 0);
      rst = 0;
      bus.px_valid = 0;
      mon_en = 0;
      @(posedge clk); #1;
      run_frame(vecs[0], "after_rst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcd_frame_streamer.md
Name: lcd_frame_streamer

Overview:
- Upstream feeder for the LCD parallel PHY; drives its phy_data/phy_rs/phy_valid/phy_ready byte interface.
- On a start request, emits the window-setup command sequence (column address set, page address set, memory write).
- Then streams a 16-bit-per-pixel stream as high/low byte pairs until the window is full.
- Can optionally hold the header until the next frame-mark strobe from the PHY, for tear-free updates.

Parameters:
- COORD_W, 9, width of window coordinate inputs (max coordinate 2^COORD_W-1).
- CMD_CASET, 8'h2A, column address set opcode.
- CMD_PASET, 8'h2B, page address set opcode.
- CMD_RAMWR, 8'h2C, memory write opcode.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle request; ignored while busy=1
- sync_fmark  in  1  sampled with start; 1 = wait for phy_fmark_stb before header
- win_x0, win_x1  in  COORD_W  first/last column, inclusive; sampled with start
- win_y0, win_y1  in  COORD_W  first/last row, inclusive; sampled with start
- busy  out  1  high from accepted start until done_stb cycle inclusive
- done_stb  out  1  one-cycle pulse when frame complete or start rejected
- px_data  in  16  pixel (RGB565)
- px_valid  in  1  pixel available
- px_ready  out  1  pixel accepted when px_valid & px_ready
- phy_data  out  8  byte to PHY
- phy_rs  out  1  0 = command, 1 = data
- phy_valid  out  1  byte valid
- phy_ready  in  1  PHY accepts byte when phy_valid & phy_ready
- phy_fmark_stb  in  1  frame-mark rising-edge strobe from PHY

Behaviour:
- Reset values: busy=0, done_stb=0, px_ready=0, phy_valid=0, phy_data=8'h00, phy_rs=0; state IDLE.
- Clock and reset: one clock domain (clk); reset is synchronous and active-high (rst).
- Output handshake:
  - phy_data/phy_rs/phy_valid are registered.
  - Once phy_valid=1, data and rs are held stable until the cycle phy_valid&phy_ready.
  - Output slot is free when phy_valid=0 or phy_ready=1; a new byte may load that same cycle.
  - Throughput is 1 byte/clk while phy_ready stays 1.
- IDLE: on start, latch coordinates and sync_fmark, set busy=1, go to SETUP.
- SETUP (1 cycle): reject if win_x1<win_x0 or win_y1<win_y0, going to DONE with no bytes emitted. Otherwise:
  - Compute pix_cnt = (x1-x0+1)*(y1-y0+1), width 2*COORD_W+2, unsigned.
  - Go to WAIT_FM if sync_fmark, else HDR.
- WAIT_FM: wait for phy_fmark_stb=1, then go to HDR. A strobe in the start cycle or in the SETUP cycle does not count.
- HDR: emit 11 bytes, index 0..10, in order:
  - CMD_CASET (rs=0)
  - x0[15:8], x0[7:0], x1[15:8], x1[7:0] (rs=1; coordinates zero-extended to 16 bits)
  - CMD_PASET (rs=0)
  - y0 hi, y0 lo, y1 hi, y1 lo (rs=1)
  - CMD_RAMWR (rs=0)
  - After byte 10 is loaded into the output register, go to PIX_HI.
- PIX_HI:
  - px_ready = output slot free; combinational from phy_valid/phy_ready.
  - On px accept: load px_data[15:8] (rs=1), store px_data[7:0], decrement pix_cnt, go to PIX_LO.
- PIX_LO:
  - When slot free, load the stored low byte (rs=1).
  - If pix_cnt==0, go to DRAIN; else go to PIX_HI.
  - px_ready=0 in this state.
- DRAIN: wait until phy_valid=0 or the final handshake completes, then go to DONE.
- DONE (1 cycle): done_stb=1, busy=1. Next cycle busy=0 and state is IDLE.
  - start in the DONE cycle is ignored.
  - start in the following cycle is accepted.
- px_ready=0 in every state except PIX_HI. No pixel is ever consumed beyond pix_cnt.
- phy_fmark_stb outside WAIT_FM is ignored.
- rst mid-operation: everything returns to reset values next cycle; any in-flight byte is dropped (phy_valid=0).

Test Plan:
- Header/window: start, x0=0,x1=1,y0=0,y1=0, phy_ready=1, pixels 16'hF800,16'h07E0.
  - Bytes out: 2A(rs0),00,00,00,01,2B(rs0),00,00,00,00,2C(rs0),F8,00,07,E0.
  - 15 consecutive valid cycles; then done_stb one pulse.
- Backpressure: same frame, phy_ready toggled pseudo-randomly.
  - Identical byte sequence.
  - phy_data/phy_rs never change while phy_valid=1 & phy_ready=0.
  - Exactly 2 pixels consumed.
- Frame-mark sync: start with sync_fmark=1; phy_fmark_stb pulsed in start cycle, then again 20 cycles later.
  - phy_valid stays 0 until after the second strobe; first CASET byte appears the cycle after it.
- Rejection: x0=5, x1=4.
  - No phy_valid; done_stb 2 cycles after start; px_ready never asserted.
- Full screen: x 0..319, y 0..239, px_valid always 1.
  - Exactly 76800 pixels accepted; 153611 bytes emitted; start during busy ignored.
- Reset mid-frame: assert rst during pixel 10.
  - Next cycle phy_valid=0, busy=0, px_ready=0.
  - A new start produces a fresh header.
